tdc_tx_sched: RTL

TDC_TX_SCHED -- requirements
Module: tdc_tx_sched

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_rr_pick.sv | 31 +++
 rtl/tdc_tx_sched.sv | 125 ++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants and FSM state type for the TDC result scheduler
package tdc_pkg;

   localparam int TDC_DATA_W     = 40;
   localparam int TDC_NUM_CH_MAX = 16;
   localparam int TDC_TAG_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tdc_state_e;

endpackage

// File: rtl/tdc_rr_pick.sv
// rtl/tdc_rr_pick.sv - combinational round-robin picker: first request after the last grant
module tdc_rr_pick #(
   parameter int NUM_CH = 4,
   parameter int IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  last_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   logic [IDX_W-1:0] cand;

   // scan from last+1 around the ring; the first requester found wins
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = IDX_W'((int'(last_i) + k) % NUM_CH);
         if (!valid_o && req_i[cand]) begin
            valid_o       = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

endmodule

// File: rtl/tdc_tx_sched.sv
// rtl/tdc_tx_sched.sv - per-channel result holding and round-robin UART launch; TDC_TX_SCHED_TAG_EN tags tx_data with the channel
module tdc_tx_sched
   import tdc_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = TDC_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [DATA_W-1:0]        tx_data,
   output logic                     tx_valid,
   input  logic                     tx_busy,
   output logic [NUM_CH-1:0]        ch_pending,
   output logic [NUM_CH-1:0]        ch_overflow,
   input  logic                     overflow_clr
);

   localparam int IDX_W = $clog2(NUM_CH);

   tdc_state_e        state_q, state_d;
   logic [DATA_W-1:0] hold_q [NUM_CH];
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] overflow_q, overflow_d;
   logic [IDX_W-1:0]  last_q;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              tx_valid_q;
   logic [NUM_CH-1:0] grant_vec;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_any;
   logic              grant_fire;

   tdc_rr_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req_i   (pending_q),
      .last_i  (last_q),
      .grant_o (grant_vec),
      .idx_o   (grant_idx),
      .valid_o (grant_any)
   );

   // transfer sequencing: grant only from IDLE with the transmitter free, then track its busy pulse
   always_comb begin
      state_d    = state_q;
      grant_fire = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_any && !tx_busy) begin
               grant_fire = 1'b1;
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH:    state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // pending/overflow bookkeeping; a fresh strobe re-arms pending even on its grant cycle, and a set beats the clear
   always_comb begin
      pending_d  = pending_q;
      overflow_d = overflow_q;
      if (overflow_clr) overflow_d = '0;
      if (grant_fire)   pending_d  = pending_q & ~grant_vec;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_valid[i]) begin
            pending_d[i] = 1'b1;
            if (pending_q[i] && !(grant_fire && grant_vec[i])) overflow_d[i] = 1'b1;
         end
      end
   end

   // outgoing payload taken from the granted holding register, optionally tagged with the channel number
   always_comb begin
      tx_data_d = hold_q[grant_idx];
`ifdef TDC_TX_SCHED_TAG_EN
      tx_data_d[DATA_W-1 -: TDC_TAG_W] = TDC_TAG_W'(grant_idx);
`endif
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // holding registers always keep the newest result of each channel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            if (ch_valid[i]) hold_q[i] <= ch_data[i*DATA_W +: DATA_W];
      end
   end

   // flags, grant pointer and transmitter-side registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= '0;
         overflow_q <= '0;
         last_q     <= IDX_W'(NUM_CH - 1);
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         tx_valid_q <= grant_fire;
         if (grant_fire) begin
            last_q    <= grant_idx;
            tx_data_q <= tx_data_d;
         end
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign ch_pending  = pending_q;
   assign ch_overflow = overflow_q;

endmodule
